i2c_target: RTL

I2C_TARGET -- requirements
Module: i2c_target

---
 rtl/i2c_target.sv | 248 ++++++++++++++++++++++++
 1 files changed

// File: rtl/i2c_target.sv
// i2c_target: I2C target (slave) with an 8-bit register pointer.
//   Writes: START, addr+W, register index, data bytes... -> one write_valid
//   pulse per data byte, pointer auto-increments (wraps at 0xFF).
//   Reads:  START, addr+R (optionally after a register-index write and a
//   repeated START) -> SCL is stretched while read_request/read_ready fetch
//   each byte from the host logic, pointer auto-increments per byte.
// Ports:
//   clock, reset                  system clock, synchronous active-high reset
//   scl_input/scl_output          raw SCL level / SCL drive (0 = hold low)
//   sda_input/sda_output          raw SDA level / SDA drive (0 = pull low)
//   write_valid/register/data     one-cycle write strobe with index and byte
//   read_request/read_register    held while a read byte is needed
//   read_ready/read_data          host response for the read handshake
//   busy                          addressed transaction in progress
module i2c_target #(
  parameter logic [6:0] ADDRESS = 7'h50
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       scl_input,
  output logic       scl_output,
  input  logic       sda_input,
  output logic       sda_output,
  output logic       write_valid,
  output logic [7:0] write_register,
  output logic [7:0] write_data,
  output logic       read_request,
  output logic [7:0] read_register,
  input  logic       read_ready,
  input  logic [7:0] read_data,
  output logic       busy
);

  typedef enum logic [3:0] {
    ST_IDLE, ST_ADDRESS, ST_ADDRESS_ACK, ST_REGISTER, ST_REGISTER_ACK,
    ST_WRITE_DATA, ST_WRITE_ACK, ST_READ_FETCH, ST_READ_DATA, ST_READ_ACK
  } state_t;

  typedef struct packed {
    logic [2:0] bit_count;      // bit position being received / on the bus
    logic       byte_done;      // 8 bits received, waiting for the SCL fall
    logic [7:0] shift;          // receive shift register
    logic [7:0] tx;             // byte being transmitted
    logic       rw;             // R/W bit of the matched address
    logic       loaded;         // read byte latched, SCL release pending
    logic [7:0] pointer;
    logic       scl_out;
    logic       sda_out;
    logic       write_valid;
    logic [7:0] write_register;
    logic [7:0] write_data;
    logic       read_request;
    logic [7:0] read_register;
    logic       busy;
  } regs_t;

  localparam regs_t REGS_RESET = '{
    bit_count: 3'd7, byte_done: 1'b0, shift: 8'h00, tx: 8'h00, rw: 1'b0,
    loaded: 1'b0, pointer: 8'h00, scl_out: 1'b1, sda_out: 1'b1,
    write_valid: 1'b0, write_register: 8'h00, write_data: 8'h00,
    read_request: 1'b0, read_register: 8'h00, busy: 1'b0
  };

  state_t state, state_next;
  regs_t  r, r_next;

  logic [1:0] scl_sync, sda_sync;
  logic       scl_prev, sda_prev;
  logic       scl_s, sda_s, scl_rise, scl_fall, start_cond, stop_cond;
  logic [7:0] rx_byte;

  // Two-flop synchronizers plus one history flop for edge detection. They
  // reset to 1 (idle bus) so leaving reset never fakes a START or STOP.
  always_ff @(posedge clock) begin
    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples pre-edge values regardless of statement order.
    if (reset) begin
      scl_sync <= 2'b11;
      sda_sync <= 2'b11;
      scl_prev <= 1'b1;
      sda_prev <= 1'b1;
    end else begin
      scl_sync <= {scl_sync[0], scl_input};
      sda_sync <= {sda_sync[0], sda_input};
      scl_prev <= scl_sync[1];
      sda_prev <= sda_sync[1];
    end
  end

  assign scl_s      = scl_sync[1];
  assign sda_s      = sda_sync[1];
  assign scl_rise   = scl_s & ~scl_prev;
  assign scl_fall   = ~scl_s & scl_prev;
  assign start_cond = scl_s & scl_prev & sda_prev & ~sda_s;
  assign stop_cond  = scl_s & scl_prev & ~sda_prev & sda_s;
  assign rx_byte    = {r.shift[6:0], sda_s};

  always_ff @(posedge clock) begin
    if (reset) begin
      state <= ST_IDLE;
      r     <= REGS_RESET;
    end else begin
      state <= state_next;
      r     <= r_next;
    end
  end

  always_comb begin
    // NOTE: every variable gets a default first so no path infers a latch.
    state_next         = state;
    r_next             = r;
    r_next.write_valid = 1'b0;

    if (start_cond) begin
      state_next          = ST_ADDRESS;
      r_next.bit_count    = 3'd7;
      r_next.byte_done    = 1'b0;
      r_next.sda_out      = 1'b1;
      r_next.scl_out      = 1'b1;
      r_next.read_request = 1'b0;
      r_next.loaded       = 1'b0;
    end else if (stop_cond) begin
      state_next          = ST_IDLE;
      r_next.sda_out      = 1'b1;
      r_next.scl_out      = 1'b1;
      r_next.busy         = 1'b0;
      r_next.read_request = 1'b0;
      r_next.loaded       = 1'b0;
    end else begin
      unique case (state)
        ST_IDLE: ;

        ST_ADDRESS, ST_REGISTER, ST_WRITE_DATA: begin
          if (scl_rise) begin
            r_next.shift = rx_byte;
            if (r.bit_count == 3'd0) begin
              r_next.byte_done = 1'b1;
              if (state == ST_REGISTER) r_next.pointer = rx_byte;
              if (state == ST_WRITE_DATA) begin
                r_next.write_valid    = 1'b1;
                r_next.write_register = r.pointer;
                r_next.write_data     = rx_byte;
                r_next.pointer        = r.pointer + 8'd1;
              end
            end else begin
              r_next.bit_count = r.bit_count - 3'd1;
            end
          end else if (scl_fall && r.byte_done) begin
            // The ACK (or the decision not to ACK) goes out while SCL is low.
            r_next.byte_done = 1'b0;
            if (state == ST_ADDRESS) begin
              if (r.shift[7:1] == ADDRESS) begin
                state_next     = ST_ADDRESS_ACK;
                r_next.sda_out = 1'b0;
                r_next.rw      = r.shift[0];
                r_next.busy    = 1'b1;
              end else begin
                state_next  = ST_IDLE;
                r_next.busy = 1'b0;
              end
            end else begin
              r_next.sda_out = 1'b0;
              state_next = (state == ST_REGISTER) ? ST_REGISTER_ACK : ST_WRITE_ACK;
            end
          end
        end

        ST_ADDRESS_ACK, ST_REGISTER_ACK, ST_WRITE_ACK: begin
          if (scl_fall) begin
            r_next.sda_out   = 1'b1;
            r_next.bit_count = 3'd7;
            if (state == ST_ADDRESS_ACK && r.rw) begin
              state_next           = ST_READ_FETCH;
              r_next.scl_out       = 1'b0;
              r_next.read_request  = 1'b1;
              r_next.read_register = r.pointer;
              r_next.loaded        = 1'b0;
            end else if (state == ST_ADDRESS_ACK) begin
              state_next = ST_REGISTER;
            end else begin
              state_next = ST_WRITE_DATA;
            end
          end
        end

        // SCL is held low here. The MSB goes onto SDA the cycle after the
        // handshake and SCL is released one cycle later, so the stretch lasts
        // at least two cycles even when read_ready is already high.
        ST_READ_FETCH: begin
          if (r.loaded) begin
            state_next       = ST_READ_DATA;
            r_next.scl_out   = 1'b1;
            r_next.loaded    = 1'b0;
            r_next.bit_count = 3'd7;
          end else if (r.read_request && read_ready) begin
            r_next.tx           = read_data;
            r_next.read_request = 1'b0;
            r_next.sda_out      = read_data[7];
            r_next.loaded       = 1'b1;
          end
        end

        // bit_count names the bit currently on the bus; each SCL fall moves on.
        ST_READ_DATA: begin
          if (scl_fall) begin
            if (r.bit_count == 3'd0) begin
              state_next     = ST_READ_ACK;
              r_next.sda_out = 1'b1;
              r_next.pointer = r.pointer + 8'd1;
            end else begin
              r_next.sda_out   = r.tx[r.bit_count - 3'd1];
              r_next.bit_count = r.bit_count - 3'd1;
            end
          end
        end

        ST_READ_ACK: begin
          if (scl_rise) begin
            r_next.shift = rx_byte;
          end else if (scl_fall) begin
            if (!r.shift[0]) begin
              state_next           = ST_READ_FETCH;
              r_next.scl_out       = 1'b0;
              r_next.read_request  = 1'b1;
              r_next.read_register = r.pointer;
              r_next.loaded        = 1'b0;
            end else begin
              // NACK: stay off the bus (busy held) until STOP or START.
              state_next = ST_IDLE;
            end
          end
        end

        default: state_next = ST_IDLE;
      endcase
    end
  end

  assign scl_output     = r.scl_out;
  assign sda_output     = r.sda_out;
  assign write_valid    = r.write_valid;
  assign write_register = r.write_register;
  assign write_data     = r.write_data;
  assign read_request   = r.read_request;
  assign read_register  = r.read_register;
  assign busy           = r.busy;

endmodule
